// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response handshake bundle for the chunked ALU
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             a_invert;
  logic             b_invert;
  logic             cin;
  logic [1:0]       operation;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, src_a, src_b, a_invert, b_invert, cin, operation, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero
  );

  modport slave (
    input  in_valid, src_a, src_b, a_invert, b_invert, cin, operation, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU computing one SLICE-bit chunk per clock
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam int NCHUNK = WIDTH / SLICE;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_r, b_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] result_r;
  logic             in_ready_r, out_valid_r, cout_r, overflow_r, zero_r;

  logic [SLICE-1:0] ac, bc, chunk;
  logic [SLICE:0]   csum;
  logic             c_msb, ovf, set_bit, last;
  logic [WIDTH-1:0] nres;
  int               base;

  always_comb begin
    base  = int'(k) * SLICE;
    last  = (k == KLAST);
    ac    = a_r[base +: SLICE];
    bc    = b_r[base +: SLICE];
    csum  = {1'b0, ac} + {1'b0, bc} + {{SLICE{1'b0}}, carry};
    // Carry into the chunk's top bit recovered from the sum bit, valid for any SLICE.
    c_msb   = ac[SLICE-1] ^ bc[SLICE-1] ^ csum[SLICE-1];
    ovf     = c_msb ^ csum[SLICE];
    set_bit = csum[SLICE-1] ^ ovf;
    case (op_r)
      2'b00:   chunk = ac & bc;
      2'b01:   chunk = ac | bc;
      default: chunk = csum[SLICE-1:0];
    endcase
    nres = result_r;
    nres[base +: SLICE] = chunk;
    if (last && op_r == 2'b11) nres = {{(WIDTH-1){1'b0}}, set_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      carry       <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= 2'b00;
      result_r    <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      cout_r      <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a_invert ? ~bus.src_a : bus.src_a;
            b_r        <= bus.b_invert ? ~bus.src_b : bus.src_b;
            op_r       <= bus.operation;
            carry      <= bus.cin;
            k          <= '0;
            in_ready_r <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          result_r <= nres;
          carry    <= csum[SLICE];
          k        <= k + KW'(1);
          if (last) begin
            cout_r      <= csum[SLICE];
            overflow_r  <= op_r[1] & ovf;
            zero_r      <= (nres == '0);
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.cout      = cout_r;
  assign bus.overflow  = overflow_r;
  assign bus.zero      = zero_r;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at 8-bit and default widths
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  if8 ();
  alu_seq_if #(.WIDTH(32)) if32 ();

  alu_seq #(.WIDTH(8), .SLICE(4)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  alu_seq dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit          sel;
    logic [31:0] a, b;
    bit          ai, bi, ci;
    logic [1:0]  op;
    int          hold;
    logic [31:0] eres;
    bit          eco, eov, ez;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [31:0] a, input logic [31:0] b,
                       input bit ai, input bit bi, input bit ci, input logic [1:0] op, input bit v);
    if8.src_a = a[7:0];    if8.src_b = b[7:0];
    if8.a_invert = ai;     if8.b_invert = bi;   if8.cin = ci;   if8.operation = op;
    if32.src_a = a;        if32.src_b = b;
    if32.a_invert = ai;    if32.b_invert = bi;  if32.cin = ci;  if32.operation = op;
    if8.in_valid  = v && !sel;
    if32.in_valid = v && sel;
  endtask

  task automatic sample(input bit sel, output logic [31:0] r, output logic co, output logic ov,
                        output logic z, output logic vld, output logic rdy);
    if (sel) begin
      r = if32.result; co = if32.cout; ov = if32.overflow; z = if32.zero;
      vld = if32.out_valid; rdy = if32.in_ready;
    end else begin
      r = {24'h0, if8.result}; co = if8.cout; ov = if8.overflow; z = if8.zero;
      vld = if8.out_valid; rdy = if8.in_ready;
    end
  endtask

  // Reference: plain-arithmetic view of the full-width operation.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                       input bit ai, input bit bi, input bit ci, input logic [1:0] op,
                       output logic [31:0] r, output logic co, output logic ov);
    logic [63:0] mask, ap, bp, s;
    logic        ovf;
    mask = (64'd1 << w) - 64'd1;
    ap   = (ai ? ~{32'h0, a} : {32'h0, a}) & mask;
    bp   = (bi ? ~{32'h0, b} : {32'h0, b}) & mask;
    s    = ap + bp + {63'h0, ci};
    co   = s[w];
    ovf  = (ap[w-1] == bp[w-1]) && (s[w-1] != ap[w-1]);
    case (op)
      2'b00:   r = ap[31:0] & bp[31:0];
      2'b01:   r = ap[31:0] | bp[31:0];
      2'b10:   r = s[31:0] & mask[31:0];
      default: r = {31'h0, s[w-1] ^ ovf};
    endcase
    ov = op[1] & ovf;
  endtask

  task automatic run(input bit sel, input logic [31:0] a, input logic [31:0] b,
                     input bit ai, input bit bi, input bit ci, input logic [1:0] op, input int hold,
                     input logic [31:0] eres, input bit eco, input bit eov, input bit ez);
    logic [31:0] r, r0;
    logic co, ov, z, vld, rdy, co0, ov0, z0;
    int lat;
    bit ok;
    @(negedge clk);
    drive(sel, a, b, ai, bi, ci, op, 1'b1);
    @(posedge clk); #1;
    drive(sel, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    lat = 0; ok = 0;
    while (!ok && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      sample(sel, r, co, ov, z, vld, rdy);
      if (vld) ok = 1;
    end
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL timeout: out_valid not seen after %0d cycles, required %0d", lat, sel ? 8 : 2);
      return;
    end
    chk("latency", lat, sel ? 32'd8 : 32'd2);
    chk("result", r, eres);
    chk("flags co/ov/z", {co, ov, z}, {eco, eov, ez});
    chk("in_ready_done", {31'h0, rdy}, 32'h0);
    r0 = r; co0 = co; ov0 = ov; z0 = z;
    repeat (hold) begin
      @(posedge clk); #1;
      sample(sel, r, co, ov, z, vld, rdy);
      chk("bp_result", r, r0);
      chk("bp_state vld/rdy/co/ov/z", {vld, rdy, co, ov, z}, {1'b1, 1'b0, co0, ov0, z0});
    end
    @(negedge clk);
    if8.out_ready = 1'b1; if32.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0; if32.out_ready = 1'b0;
    sample(sel, r, co, ov, z, vld, rdy);
    chk("release vld/rdy", {vld, rdy}, 2'b01);
  endtask

  initial begin
    logic [31:0] r, er, ra, rb;
    logic co, ov, z, vld, rdy, eco, eov;
    bit sel, ai, bi, ci;
    logic [1:0] op;

    tbl[0] = '{0, 32'h7F, 32'h01, 0, 0, 0, 2'b10, 5, 32'h80, 0, 1, 0};
    tbl[1] = '{0, 32'h05, 32'h05, 0, 1, 1, 2'b10, 0, 32'h00, 1, 0, 1};
    tbl[2] = '{0, 32'hFD, 32'h02, 0, 1, 1, 2'b11, 1, 32'h01, 1, 0, 0};
    tbl[3] = '{0, 32'h80, 32'h01, 0, 1, 1, 2'b11, 0, 32'h01, 1, 1, 0};
    tbl[4] = '{0, 32'h02, 32'hFD, 0, 1, 1, 2'b11, 0, 32'h00, 0, 0, 1};
    tbl[5] = '{1, 32'h0000FFFF, 32'hFFFF0000, 1, 1, 0, 2'b00, 0, 32'h00000000, 0, 0, 1};
    tbl[6] = '{1, 32'h0F0F0F0F, 32'hF0F0F0F0, 0, 0, 0, 2'b01, 2, 32'hFFFFFFFF, 0, 0, 0};
    tbl[7] = '{1, 32'h3, 32'h4, 0, 0, 0, 2'b10, 0, 32'h7, 0, 0, 0};
    tbl[8] = '{0, 32'hF0, 32'h3C, 1, 1, 0, 2'b01, 0, 32'hCF, 0, 0, 0};
    tbl[9] = '{1, 32'h0, 32'h1, 0, 1, 1, 2'b10, 0, 32'hFFFFFFFF, 0, 0, 0};

    rst = 1'b1;
    if8.out_ready = 1'b0; if32.out_ready = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0, 0, 2'b00, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s[0], r, co, ov, z, vld, rdy);
      chk("reset result", r, 32'h0);
      chk("reset rdy/vld/co/ov/z", {rdy, vld, co, ov, z}, 5'b10000);
    end
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].ai, tbl[i].bi, tbl[i].ci, tbl[i].op,
          tbl[i].hold, tbl[i].eres, tbl[i].eco, tbl[i].eov, tbl[i].ez);

    // Drop an 8-bit operation halfway through BUSY.
    @(negedge clk);
    drive(0, 32'h55, 32'h22, 0, 0, 0, 2'b10, 1);
    @(posedge clk); #1;
    drive(0, 32'h0, 32'h0, 0, 0, 0, 2'b00, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    sample(0, r, co, ov, z, vld, rdy);
    chk("midbusy_rst result", r, 32'h0);
    chk("midbusy_rst rdy/vld/co/ov/z", {rdy, vld, co, ov, z}, 5'b10000);
    @(negedge clk) rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      sample(0, r, co, ov, z, vld, rdy);
      chk("dropped_op vld/rdy", {vld, rdy}, 2'b01);
    end
    run(0, 32'h3, 32'h4, 0, 0, 0, 2'b10, 0, 32'h7, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      sel = i[0];
      ra = $urandom; rb = $urandom;
      ai = 1'($urandom_range(0, 1)); bi = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      model(sel ? 32 : 8, ra, rb, ai, bi, ci, op, er, eco, eov);
      run(sel, ra, rb, ai, bi, ci, op, $urandom_range(0, 2), er, eco, eov, er == 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle successor to the 4-bit ripple ALU slice: a WIDTH-bit ALU that evaluates one SLICE-bit chunk per clock, carrying the ripple carry between chunks in a register. It keeps the slice's control set (A/B invert, carry-in, 2-bit operation including set-less-than). It adds valid/ready handshakes, operand capture and zero/overflow/carry flags. It sits between the datapath register file and writeback where area matters more than single-cycle latency.

## Interface
- WIDTH, default 32: operand/result width; must be a multiple of SLICE, at least 2.
- SLICE, default 4: bits processed per cycle; NCHUNK = WIDTH/SLICE.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- src_a, src_b  input  WIDTH  operands.
- a_invert, b_invert  input  1  invert the A or B operand before the operation.
- cin  input  1  carry into bit 0; 1 with b_invert gives subtract.
- operation  input  2  operation select: 00 AND, 01 OR, 10 ADD, 11 SLT.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- cout  output  1  adder carry out of bit WIDTH-1.
- overflow  output  1  signed overflow; ADD and SLT only.
- zero  output  1  result is all zeros.

## Operation
- A' = a_invert ? ~src_a : src_a and B' = b_invert ? ~src_b : src_b, captured at accept.
- The adder path runs for every operation.
- AND gives A'&B'. OR gives A'|B'. ADD gives A'+B'+cin.
- NOR is AND with both inverts set. NAND is OR with both inverts set.
- SLT: the adder computes A'+B'+cin, normally with b_invert=1 and cin=1. The result is {WIDTH-1 zeros, set}, with set = sum[WIDTH-1] XOR overflow.
- overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, for operation 1x. It is 0 for AND and OR.
- cout is the adder carry out for every operation.
- zero = (result == 0), computed on the final registered result.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid=1, capture A', B', operation and cin; clear the chunk counter; go to BUSY.
- BUSY: each cycle, chunk k (bits k*SLICE .. k*SLICE+SLICE-1) is computed from the registered carry.
  - Result bits for chunk k are written.
  - The carry register updates.
  - k increments.
  - On the chunk k = NCHUNK-1, the flags and the SLT bit are finalised in the same edge and the FSM goes to DONE.
- DONE: out_valid=1. result and flags are held stable until out_ready=1, then the FSM goes to IDLE.
- Inputs other than in_valid are ignored outside the accept cycle.
- in_ready is 0 in BUSY and DONE. A request cannot be accepted in the same cycle a result is released.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, cout=0, overflow=0, zero=0, internal carry and counter 0.
- Accept on edge t leads to out_valid=1 after edge t+NCHUNK. With defaults, latency is 8 cycles.
- Minimum issue interval is NCHUNK+2 cycles when out_ready is held at 1.
- Backpressure: out_valid, result and flags must not change while out_valid=1 and out_ready=0.
- When NCHUNK=1, BUSY lasts a single cycle.
- rst asserted in any state clears everything to the reset values immediately. An in-flight operation is dropped and no out_valid is produced for it.
- in_valid while in_ready=0 has no effect. The requester holds the request until in_ready=1.
- Carry wraps out of the top bit into cout only; it never wraps back into bit 0.

## Test plan
- WIDTH=8, SLICE=4. ADD 0x7F+0x01, cin=0 -> result 0x80, overflow=1, cout=0, zero=0. out_valid rises exactly 2 cycles after accept.
- WIDTH=8. Subtract 0x05-0x05 (b_invert=1, cin=1, op 10) -> result 0x00, zero=1, cout=1, overflow=0.
- WIDTH=8. SLT 0xFD vs 0x02 (b_invert=1, cin=1, op 11) -> result 0x01. SLT 0x80 vs 0x01 -> 0x01, with overflow=1 handled. SLT 0x02 vs 0xFD -> 0x00.
- Defaults. NOR of 0x0000FFFF and 0xFFFF0000 (both inverts, op 00) -> result 0x00000000, zero=1. OR 0x0F0F0F0F | 0xF0F0F0F0 -> 0xFFFFFFFF, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flags unchanged and in_ready=0 throughout. Raise out_ready -> in_ready=1 on the next cycle.
- Assert rst for one cycle mid-BUSY -> all outputs read 0 and in_ready=1 immediately, with no out_valid for the dropped operation. A new ADD 3+4 then returns 7.
